// File: rtl/vga_pkg.sv
// Shared VGA constants, sprite attribute record and renderer FSM states.
package vga_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int POS_W        = 10;
  // Colour field width held in each sprite record (3 bits per channel).
  localparam int ATTR_COLOR_W = 9;

  typedef struct packed {
    logic                    on;
    logic [POS_W-1:0]        x;
    logic [POS_W-1:0]        y;
    logic [ATTR_COLOR_W-1:0] color;
  } sprite_attr_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    COMMIT
  } fsm_state_t;

endpackage

// File: rtl/sprite_hit.sv
// Combinational box test for one sprite. Bounds are widened by one bit so a
// sprite placed near column/row 1023 does not wrap back to the left/top edge.
module sprite_hit
  import vga_pkg::*;
#(
  parameter int SPR_SIZE = 16
) (
  input  logic             on,
  input  logic [POS_W-1:0] x,
  input  logic [POS_W-1:0] y,
  input  logic [POS_W-1:0] hpos,
  input  logic [POS_W-1:0] vpos,
  output logic             hit
);

  logic [POS_W:0] h_ext;
  logic [POS_W:0] v_ext;
  logic [POS_W:0] x_lo;
  logic [POS_W:0] y_lo;
  logic [POS_W:0] x_hi;
  logic [POS_W:0] y_hi;

  assign h_ext = {1'b0, hpos};
  assign v_ext = {1'b0, vpos};
  assign x_lo  = {1'b0, x};
  assign y_lo  = {1'b0, y};
  assign x_hi  = x_lo + (POS_W+1)'(SPR_SIZE);
  assign y_hi  = y_lo + (POS_W+1)'(SPR_SIZE);

  assign hit = on && (h_ext >= x_lo) && (h_ext < x_hi) &&
               (v_ext >= y_lo) && (v_ext < y_hi);

endmodule

// File: rtl/sprite_renderer.sv
// Sprite renderer: two-stage pixel pipeline between the VGA sync generator and
// the DAC. Sprite attributes are written into shadow registers and copied to
// the live set once per frame on the rising edge of end_frame_in.
// Optional build macro: BORDER_EN draws an all-ones frame around the visible
// area, overriding sprites and background.
module sprite_renderer
  import vga_pkg::*;
#(
  parameter int                 NSPR     = 4,
  parameter int                 SPR_SIZE = 16,
  parameter int                 COLOR_W  = ATTR_COLOR_W,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [POS_W-1:0]   hpos,
  input  logic [POS_W-1:0]   vpos,
  input  logic               pxl_en,
  input  logic               end_frame_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [2:0]         wr_idx,
  input  logic [POS_W-1:0]   wr_x,
  input  logic [POS_W-1:0]   wr_y,
  input  logic [COLOR_W-1:0] wr_color,
  input  logic               wr_on,
  output logic [COLOR_W-1:0] rgb,
  output logic               hsync,
  output logic               vsync,
  output logic               collision
);

  localparam int CNT_W = $clog2(NSPR + 1);

  fsm_state_t   state;
  fsm_state_t   state_nxt;
  logic         commit;
  logic         end_frame_q;
  logic         frame_rise;

  sprite_attr_t shadow [NSPR];
  sprite_attr_t live   [NSPR];

  logic [NSPR-1:0]    hit_vec;
  logic [COLOR_W-1:0] sel_color;
  logic               any_hit;
  logic [CNT_W-1:0]   hit_cnt;
  logic               multi_hit;

  logic [COLOR_W-1:0] color_q;
  logic               hit_q;
  logic               multi_q;
  logic               en_q;
  logic               hs_q;
  logic               vs_q;
  logic [COLOR_W-1:0] rgb_nxt;
  logic               set_now;
  logic               sticky;

  assign frame_rise = end_frame_in && !end_frame_q;

  // State register.
  // NOTE: clocked state is always written with <= so every flop samples the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: leave IDLE at once, commit once per end_frame_in edge.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = RUN;
      RUN:     if (frame_rise) state_nxt = COMMIT;
      COMMIT:  state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: writes are accepted only in RUN, the copy happens in COMMIT.
  always_comb begin
    wr_ready = 1'b0;
    commit   = 1'b0;
    case (state)
      RUN:     wr_ready = 1'b1;
      COMMIT:  commit   = 1'b1;
      default: ;
    endcase
  end

  // Previous end_frame_in level for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) end_frame_q <= 1'b0;
    else      end_frame_q <= end_frame_in;
  end

  // Shadow attribute registers; out-of-range indices are dropped.
  // NOTE: these small register arrays are reset explicitly because a stale
  // enabled sprite after reset would be visible on screen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NSPR; i++) shadow[i] <= '0;
    end else if (wr_valid && wr_ready) begin
      for (int i = 0; i < NSPR; i++) begin
        if (wr_idx == 3'(i)) begin
          shadow[i].on    <= wr_on;
          shadow[i].x     <= wr_x;
          shadow[i].y     <= wr_y;
          shadow[i].color <= ATTR_COLOR_W'(wr_color);
        end
      end
    end
  end

  // Live attribute set, updated atomically during COMMIT only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NSPR; i++) live[i] <= '0;
    end else if (commit) begin
      live <= shadow;
    end
  end

  for (genvar g = 0; g < NSPR; g++) begin : g_hit
    sprite_hit #(.SPR_SIZE(SPR_SIZE)) u_hit (
      .on   (live[g].on),
      .x    (live[g].x),
      .y    (live[g].y),
      .hpos (hpos),
      .vpos (vpos),
      .hit  (hit_vec[g])
    );
  end

  // Priority select (lowest index wins) and hit count for collision.
  // NOTE: blocking assignments here let each loop iteration build on the last.
  always_comb begin
    sel_color = '0;
    any_hit   = 1'b0;
    hit_cnt   = '0;
    for (int i = NSPR - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        sel_color = COLOR_W'(live[i].color);
        any_hit   = 1'b1;
      end
    end
    for (int i = 0; i < NSPR; i++) hit_cnt = hit_cnt + CNT_W'(hit_vec[i]);
  end

  assign multi_hit = (hit_cnt > CNT_W'(1));

  // Stage 1: register the sprite decision alongside the delayed sync/enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      color_q <= '0;
      hit_q   <= 1'b0;
      multi_q <= 1'b0;
      en_q    <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
    end else begin
      color_q <= sel_color;
      hit_q   <= any_hit;
      multi_q <= multi_hit;
      en_q    <= pxl_en;
      hs_q    <= hsync_in;
      vs_q    <= vsync_in;
    end
  end

`ifdef BORDER_EN
  logic border_q;

  // Stage 1 border flag for the outermost visible rows and columns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) border_q <= 1'b0;
    else      border_q <= (hpos == POS_W'(0)) || (hpos == POS_W'(H_ACTIVE - 1)) ||
                          (vpos == POS_W'(0)) || (vpos == POS_W'(V_ACTIVE - 1));
  end

  // Stage 2 colour: blank, border, sprite or background.
  always_comb begin
    rgb_nxt = '0;
    if (en_q) begin
      if (border_q)   rgb_nxt = '1;
      else if (hit_q) rgb_nxt = color_q;
      else            rgb_nxt = BG_COLOR;
    end
  end
`else
  // Stage 2 colour: blank, sprite or background.
  always_comb begin
    rgb_nxt = '0;
    if (en_q) rgb_nxt = hit_q ? color_q : BG_COLOR;
  end
`endif

  // Stage 2 output registers driving the DAC pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      rgb   <= rgb_nxt;
      hsync <= hs_q;
      vsync <= vs_q;
    end
  end

  assign set_now = en_q && multi_q;

  // Sticky overlap flag for the current frame, published on every commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky    <= 1'b0;
      collision <= 1'b0;
    end else if (commit) begin
      collision <= sticky || set_now;
      sticky    <= 1'b0;
    end else if (set_now) begin
      sticky    <= 1'b1;
    end
  end

endmodule
